morse_keyer: RTL and testbench

//  Consumer stage for the character-to-Morse lookup ROM. Accepts one character over a

---
 rtl/morse_pkg.sv | 30 +++
 rtl/morse_unit_timer.sv | 24 ++
 rtl/morse_keyer.sv | 120 ++++++++++++
 tb/tb_morse_keyer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding, ROM pattern fields and Morse unit lengths for the keyer
package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_MARK,
        S_GAP,
        S_CHAR_GAP,
        S_WORD_GAP
    } state_t;

    localparam int CNT_MSB = 7;
    localparam int CNT_LSB = 5;
    localparam int EL_MSB = 4;
    localparam logic [2:0] MAX_ELEMS = 3'd5;

    localparam logic [2:0] DOT = 3'd1;
    localparam logic [2:0] DASH = 3'd3;
    localparam logic [2:0] EL_GAP = 3'd1;
    localparam logic [2:0] CHAR_GAP = 3'd3;
    localparam logic [2:0] WORD_GAP = 3'd7;

    // element count field, with the unused codes 6 and 7 clamped to the 5 element bits available
    function automatic logic [2:0] elem_count(input logic [7:0] pat);
        return (pat[CNT_MSB:CNT_LSB] > MAX_ELEMS) ? MAX_ELEMS : pat[CNT_MSB:CNT_LSB];
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// morse_unit_timer: free-running unit prescaler, held at zero by i_clear, ticks once per UNIT_CYCLES clocks
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 6_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    output logic o_unit_tick
);

    localparam int W = $clog2(UNIT_CYCLES);
    localparam logic [W-1:0] LAST = W'(UNIT_CYCLES - 1);

    logic [W-1:0] r_cnt;

    assign o_unit_tick = (r_cnt == LAST);

    // count 0..UNIT_CYCLES-1; clearing aligns every interval to its entry edge
    always_ff @(posedge clk) begin
        if (reset || i_clear) r_cnt <= '0;
        else r_cnt <= o_unit_tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: accepts a character, looks it up in the Morse ROM and keys it out with standard timing.
// Optional sidetone square wave on tone_out when SIDETONE_EN is defined.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 6_000_000,
    parameter int TONE_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic       key_out,
    output logic       tone_out,
    output logic       busy,
    output logic       done
);

    state_t     r_state;
    logic [7:0] r_addr;
    logic [4:0] r_pat;
    logic [2:0] r_left;
    logic [2:0] r_units;
    logic       r_key;
    logic       r_done;
    logic       w_tick;
    logic       w_clr;
    logic       w_last;
    logic [2:0] w_len;

    assign char_ready = (r_state == S_IDLE);
    assign busy = ~char_ready;
    assign rom_addr = r_addr;
    assign key_out = r_key;
    assign done = r_done;

    // prescaler only runs in the timed states so each interval starts on a fresh unit
    assign w_clr = (r_state == S_IDLE) || (r_state == S_FETCH) || (r_state == S_CAPTURE);

    // length in units of the interval currently being timed; MSB of the pattern is the current element
    assign w_len = (r_state == S_MARK) ? (r_pat[EL_MSB] ? DASH : DOT) :
                   (r_state == S_GAP) ? EL_GAP :
                   (r_state == S_CHAR_GAP) ? CHAR_GAP : WORD_GAP;
    assign w_last = w_tick && (r_units == w_len - 3'd1);

    morse_unit_timer #(.UNIT_CYCLES(UNIT_CYCLES)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_clr),
        .o_unit_tick(w_tick)
    );

    // handshake, ROM fetch, element sequencing; key follows MARK one clock later
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= 8'd0;
            r_pat   <= 5'd0;
            r_left  <= 3'd0;
            r_units <= 3'd0;
            r_key   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_key  <= (r_state == S_MARK);
            r_done <= 1'b0;
            if (w_tick) r_units <= w_last ? 3'd0 : r_units + 3'd1;
            case (r_state)
                S_IDLE: if (char_valid) begin
                    r_addr  <= char_in;
                    r_state <= S_FETCH;
                end
                S_FETCH: r_state <= S_CAPTURE;
                S_CAPTURE: begin
                    r_pat   <= rom_data[EL_MSB:0];
                    r_left  <= elem_count(rom_data);
                    r_state <= (elem_count(rom_data) == 3'd0) ? S_WORD_GAP : S_MARK;
                end
                S_MARK: if (w_last) begin
                    r_pat   <= {r_pat[EL_MSB-1:0], 1'b0};
                    r_left  <= r_left - 3'd1;
                    r_state <= (r_left > 3'd1) ? S_GAP : S_CHAR_GAP;
                end
                S_GAP: if (w_last) r_state <= S_MARK;
                default: if (w_last) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
            endcase
        end
    end

`ifdef SIDETONE_EN
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [TW-1:0] r_tdiv;
    logic          r_tone;

    assign tone_out = r_tone & r_key;

    // square wave while keyed; divider and phase restart whenever the key is up
    always_ff @(posedge clk) begin
        if (reset || !r_key) begin
            r_tdiv <= '0;
            r_tone <= 1'b0;
        end else if (r_tdiv == TW'(TONE_DIV - 1)) begin
            r_tdiv <= '0;
            r_tone <= ~r_tone;
        end else begin
            r_tdiv <= r_tdiv + 1'b1;
        end
    end
`else
    // no sidetone: constant low
    assign tone_out = (TONE_DIV < 0);
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// tb_morse_keyer: random and directed stimulus against a per-cycle waveform model built from Morse timing rules
module tb_morse_keyer;

    localparam int U = 4;
    localparam int TD = 2;

    typedef struct packed {
        logic key;
        logic busy;
        logic ready;
        logic done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       char_valid = 1'b0;
    logic [7:0] char_in = 8'd0;
    logic       char_ready, key_out, tone_out, busy, done;
    logic [7:0] rom_addr, rom_data;
    logic [7:0] rom [256];

    exp_t       q[$];
    logic       m_ready = 1'b1;
    logic [7:0] m_addr = 8'd0;
    logic       chk_en = 1'b0;
    int         total = 0;
    int         bad = 0;
    int         rec_done;
    int         runs[$];
    int         want[$];

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    morse_keyer #(.UNIT_CYCLES(U), .TONE_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .char_in   (char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .key_out   (key_out),
        .tone_out  (tone_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // expected outputs for every clock after the transfer edge: 2 fetch clocks, the Morse
    // timeline (key lags the timeline by one clock), then the done/idle clock
    function automatic void expand(input logic [7:0] b);
        bit s[$];
        bit prev;
        int n;
        n = (b[7:5] > 3'd5) ? 5 : int'(b[7:5]);
        if (n == 0) begin
            repeat (7 * U) s.push_back(1'b0);
        end else begin
            for (int i = 0; i < n; i++) begin
                repeat ((b[4-i] ? 3 : 1) * U) s.push_back(1'b1);
                repeat ((i == n - 1 ? 3 : 1) * U) s.push_back(1'b0);
            end
        end
        repeat (2) q.push_back('{key: 1'b0, busy: 1'b1, ready: 1'b0, done: 1'b0});
        prev = 1'b0;
        for (int j = 0; j < s.size(); j++) begin
            q.push_back('{key: prev, busy: 1'b1, ready: 1'b0, done: 1'b0});
            prev = s[j];
        end
        q.push_back('{key: prev, busy: 1'b0, ready: 1'b1, done: 1'b1});
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_addr = 8'd0;
            chk_en = 1'b1;
        end else if (char_valid && m_ready) begin
            m_addr = char_in;
            expand(rom[char_in]);
        end
    end

    always @(negedge clk) begin : cmp
        exp_t e;
        e = '{key: 1'b0, busy: 1'b0, ready: 1'b1, done: 1'b0};
        if (q.size() != 0) e = q.pop_front();
        m_ready = e.ready;
        if (chk_en) begin
            check("key_out", key_out, e.key);
            check("busy", busy, e.busy);
            check("char_ready", char_ready, e.ready);
            check("done", done, e.done);
            check("rom_addr", rom_addr, m_addr);
            check("tone_key_up", tone_out & ~e.key, 0);
        end
    end

    task automatic send(input logic [7:0] ch);
        @(negedge clk);
        char_in = ch;
        char_valid = 1'b1;
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    // run-length record of key_out from the current clock through the done clock
    task automatic record();
        logic lvl;
        int len;
        int c;
        runs.delete();
        lvl = 1'b0;
        len = 0;
        c = 0;
        forever begin
            if (key_out === lvl) len++;
            else begin
                runs.push_back(len);
                lvl = key_out;
                len = 1;
            end
            if (done === 1'b1 || c >= 300) break;
            @(negedge clk);
            c++;
        end
        runs.push_back(len);
        rec_done = c;
        check("record_reached_done", done, 1);
    endtask

    task automatic expect_runs(input string name, input int want_done);
        check({name, "_nruns"}, runs.size(), want.size());
        for (int i = 0; i < want.size() && i < runs.size(); i++) check({name, "_run"}, runs[i], want[i]);
        check({name, "_done_at"}, rec_done, want_done);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h45] = 8'b001_0_1011;
        rom[8'h41] = 8'b010_01_110;
        rom[8'h54] = 8'b001_1_0101;
        rom[8'h20] = 8'b000_11111;
        rom[8'hFF] = 8'b111_11111;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'h45);
        record();
        want = '{3, 4, 12};
        expect_runs("E", 18);
        send(8'h41);
        record();
        want = '{3, 4, 4, 12, 12};
        expect_runs("A", 34);
        send(8'h20);
        record();
        want = '{31};
        expect_runs("space", 30);
        send(8'hFF);
        record();
        want = '{3, 12, 4, 12, 4, 12, 4, 12, 4, 12, 12};
        expect_runs("sat5", 90);
        @(negedge clk);
        char_in = 8'h45;
        char_valid = 1'b1;
        @(negedge clk);
        char_in = 8'h54;
        record();
        want = '{3, 4, 12};
        expect_runs("b2b_E", 18);
        @(negedge clk);
        check("b2b_busy", busy, 1);
        check("b2b_ready", char_ready, 0);
        char_valid = 1'b0;
        record();
        want = '{3, 12, 12};
        expect_runs("b2b_T", 26);
        send(8'h54);
        repeat (6) @(negedge clk);
        check("mid_dash_key", key_out, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_key", key_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", char_ready, 1);
        check("rst_tone", tone_out, 0);
        repeat (4000) begin
            @(negedge clk);
            char_valid = ($urandom_range(0, 3) == 0);
            char_in = 8'($urandom);
            reset = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        char_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
